// File: rtl/nibble_word_assembler_pkg.sv
// Shared widths, slot map and state encoding for the nibble word path.
// The read-side nibble mux uses the same slot-to-bit mapping.
package nibble_word_assembler_pkg;

   localparam int NIB_W   = 4;
   localparam int NUM_NIB = 4;
   localparam int WORD_W  = NIB_W * NUM_NIB;
   localparam int ADR_W   = $clog2(NUM_NIB);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/nibble_slot_decoder.sv
// Slot address to one-hot write enable.
// Slot k selects word bits [NIB_W*k +: NIB_W].
module nibble_slot_decoder
   import nibble_word_assembler_pkg::*;
(
   input  logic [ADR_W-1:0]   adr_i,
   output logic [NUM_NIB-1:0] onehot_o
);

   always_comb begin
      onehot_o        = '0;
      onehot_o[adr_i] = 1'b1;
   end

endmodule

// File: rtl/nibble_word_assembler.sv
// Collects slot-addressed nibbles into a word, presents it on a
// valid/ready output once every slot has been written.
module nibble_word_assembler
   import nibble_word_assembler_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic [NIB_W-1:0]   in_nib,
   input  logic [ADR_W-1:0]   in_adr,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WORD_W-1:0]  out_word,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUM_NIB-1:0] fill_mask,
   output logic [CNT_W-1:0]   word_cnt,
   output logic               dup_err
);

   state_e               state_q, state_d;
   logic [WORD_W-1:0]    stage_q, stage_d;
   logic [WORD_W-1:0]    word_q, word_d;
   logic [NUM_NIB-1:0]   mask_q, mask_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 dup_q, dup_d;

   logic [NUM_NIB-1:0]   onehot;
   logic [NUM_NIB-1:0]   mask_nxt;
   logic                 accept;
   logic                 dup_hit;
   logic                 done;

   nibble_slot_decoder u_dec (
      .adr_i    (in_adr),
      .onehot_o (onehot)
   );

   // Ready is gated by rst_n so nothing is taken while in reset.
   assign in_ready = rst_n && ((state_q == FILL) || out_ready);
   assign accept   = in_valid && in_ready && !clr;
   assign dup_hit  = |(mask_q & onehot);
   assign mask_nxt = mask_q | onehot;
   assign done     = accept && (mask_nxt == '1) && !dup_hit;

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      word_d  = word_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      dup_d   = dup_q;

      for (int k = 0; k < NUM_NIB; k++) begin
         if (accept && onehot[k]) begin
            stage_d[k*NIB_W +: NIB_W] = in_nib;
         end
      end

      if (clr) begin
         state_d = FILL;
         stage_d = '0;
         mask_d  = '0;
         dup_d   = 1'b0;
      end else begin
         if ((state_q == HOLD) && out_ready) begin
            state_d = FILL;
         end
         if (accept) begin
            mask_d = mask_nxt;
            if (dup_hit) begin
               dup_d = 1'b1;
            end
         end
         if (done) begin
            word_d  = stage_d;
            state_d = HOLD;
            mask_d  = '0;
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         stage_q <= '0;
         word_q  <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         dup_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         word_q  <= word_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         dup_q   <= dup_d;
      end
   end

   assign out_word  = word_q;
   assign out_valid = (state_q == HOLD);
   assign fill_mask = mask_q;
   assign word_cnt  = cnt_q;
   assign dup_err   = dup_q;

endmodule

// File: tb/tb_nibble_word_assembler.sv
// Scoreboard bench for nibble_word_assembler: directed plan steps
// followed by random traffic against a slot-array reference model.
module tb_nibble_word_assembler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  in_nib = '0;
   logic [1:0]  in_adr = '0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic [15:0] out_word;
   logic        out_valid;
   logic [3:0]  fill_mask;
   logic [7:0]  word_cnt;
   logic        dup_err;

   nibble_word_assembler #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .in_nib    (in_nib),
      .in_adr    (in_adr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_word  (out_word),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fill_mask (fill_mask),
      .word_cnt  (word_cnt),
      .dup_err   (dup_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [15:0] w;
      logic [7:0]  c;
   } exp_t;

   exp_t       q[$];
   logic [3:0] m_nib[4];
   logic [3:0] m_wr;
   bit         m_hold;
   bit         m_dup;
   int         m_cnt;
   bit         mon_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_nib[i] = '0;
      m_wr   = '0;
      m_hold = 1'b0;
      m_dup  = 1'b0;
      m_cnt  = 0;
      q.delete();
   endtask

   // One clock edge of the reference: slots filled as a set, a word
   // is emitted when the set becomes complete.
   task automatic model_step();
      bit rdy;
      if (!rst_n) return;
      if (clr) begin
         for (int i = 0; i < 4; i++) m_nib[i] = '0;
         m_wr   = '0;
         m_dup  = 1'b0;
         m_hold = 1'b0;
         q.delete();
         return;
      end
      rdy = !m_hold || out_ready;
      if (m_hold && out_ready) m_hold = 1'b0;
      if (in_valid && rdy) begin
         if (m_wr[in_adr]) m_dup = 1'b1;
         m_nib[in_adr] = in_nib;
         m_wr[in_adr]  = 1'b1;
         if (m_wr == 4'hF) begin
            m_cnt = (m_cnt + 1) % 256;
            q.push_back('{w: {m_nib[3], m_nib[2], m_nib[1], m_nib[0]},
                          c: 8'(m_cnt)});
            m_wr   = '0;
            m_hold = 1'b1;
         end
      end
   endtask

   task automatic drive(input bit v, input logic [1:0] a,
                        input logic [3:0] d, input bit r, input bit c);
      in_valid  = v;
      in_adr    = a;
      in_nib    = d;
      out_ready = r;
      clr       = c;
      @(posedge clk);
      model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         chk("out_valid", 32'(out_valid), 32'(m_hold));
         chk("fill_mask", 32'(fill_mask), 32'(m_wr));
         chk("dup_err", 32'(dup_err), 32'(m_dup));
         chk("in_ready", 32'(in_ready), 32'(!m_hold || out_ready));
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("word_queue", 32'(q.size()), 32'd1);
            end else begin
               chk("out_word", 32'(out_word), 32'(q[0].w));
               if (out_ready && !clr) begin
                  chk("word_cnt", 32'(word_cnt), 32'(q[0].c));
                  void'(q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_word", 32'(out_word), 32'h0000);
      chk("rst_fill_mask", 32'(fill_mask), 32'd0);
      chk("rst_word_cnt", 32'(word_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_dup_err", 32'(dup_err), 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      mon_en = 1'b1;

      // in-order fill
      drive(1, 2'd0, 4'h4, 1, 0);
      drive(1, 2'd1, 4'h3, 1, 0);
      drive(1, 2'd2, 4'h2, 1, 0);
      drive(1, 2'd3, 4'h1, 1, 0);
      chk("t2_word", 32'(out_word), 32'h1234);
      chk("t2_valid", 32'(out_valid), 32'd1);
      drive(0, 2'd0, 4'h0, 1, 0);
      chk("t2_cnt", 32'(word_cnt), 32'd1);
      chk("t2_valid_drop", 32'(out_valid), 32'd0);

      // out-of-order fill
      drive(1, 2'd3, 4'hA, 1, 0);
      chk("t3_mask1", 32'(fill_mask), 32'b1000);
      drive(1, 2'd1, 4'hB, 1, 0);
      chk("t3_mask2", 32'(fill_mask), 32'b1010);
      drive(1, 2'd0, 4'hC, 1, 0);
      chk("t3_mask3", 32'(fill_mask), 32'b1011);
      drive(1, 2'd2, 4'hD, 1, 0);
      chk("t3_word", 32'(out_word), 32'hADBC);
      chk("t3_mask4", 32'(fill_mask), 32'b0000);
      drive(0, 2'd0, 4'h0, 1, 0);

      // duplicate write
      drive(1, 2'd0, 4'h5, 1, 0);
      drive(1, 2'd0, 4'h6, 1, 0);
      chk("t4_dup", 32'(dup_err), 32'd1);
      drive(1, 2'd1, 4'h7, 1, 0);
      drive(1, 2'd2, 4'h8, 1, 0);
      chk("t4_not_done", 32'(out_valid), 32'd0);
      drive(1, 2'd3, 4'h9, 1, 0);
      chk("t4_word", 32'(out_word), 32'h9876);
      drive(0, 2'd0, 4'h0, 1, 0);

      // backpressure
      drive(1, 2'd0, 4'h1, 0, 0);
      drive(1, 2'd1, 4'h2, 0, 0);
      drive(1, 2'd2, 4'h3, 0, 0);
      drive(1, 2'd3, 4'h4, 0, 0);
      repeat (5) drive(0, 2'd0, 4'h0, 0, 0);
      chk("t5_in_ready", 32'(in_ready), 32'd0);
      chk("t5_word", 32'(out_word), 32'h4321);
      drive(1, 2'd1, 4'hE, 1, 0);
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_mask", 32'(fill_mask), 32'b0010);
      drive(0, 2'd0, 4'h0, 1, 0);

      // clr then async reset mid-HOLD
      drive(1, 2'd2, 4'h5, 1, 0);
      drive(1, 2'd3, 4'h6, 1, 0);
      drive(0, 2'd0, 4'h0, 1, 1);
      chk("t6_clr_mask", 32'(fill_mask), 32'd0);
      chk("t6_clr_dup", 32'(dup_err), 32'd0);
      chk("t6_clr_cnt", 32'(word_cnt), 32'd4);
      drive(1, 2'd0, 4'h1, 0, 0);
      drive(1, 2'd1, 4'h1, 0, 0);
      drive(1, 2'd2, 4'h1, 0, 0);
      drive(1, 2'd3, 4'h1, 0, 0);
      drive(0, 2'd0, 4'h0, 0, 0);
      chk("t6_hold", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_cnt", 32'(word_cnt), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;

      // random traffic
      repeat (400) begin
         drive($urandom_range(0, 99) < 70, 2'($urandom),
               4'($urandom), $urandom_range(0, 99) < 60,
               $urandom_range(0, 99) < 3);
      end
      repeat (6) drive(0, 2'd0, 4'h0, 1, 0);
      chk("leftover", 32'(q.size()), 32'd0);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nibble_word_assembler.md
Name: nibble_word_assembler

Overview:
- Write-side counterpart of the nibble-select read mux. It collects 4-bit nibbles, each tagged with a 2-bit slot address, into a 16-bit staging word.
- Once every slot has been written, it presents the full word on a valid/ready output and holds it until the word is accepted.
- Sits between a nibble-serial source (keypad/serial loader) and the 16-bit counter preload/display registers.

Parameters:
- NIB_W, 4, nibble width in bits.
- NUM_NIB, 4, nibbles per word; word width = NIB_W*NUM_NIB = 16.
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear, active high.
- in_nib  input  4  nibble data.
- in_adr  input  2  slot address; slot k maps to word bits [4k+3:4k].
- in_valid  input  1  nibble present.
- in_ready  output  1  nibble accepted this cycle when in_valid && in_ready.
- out_word  output  16  assembled word (registered).
- out_valid  output  1  out_word holds a complete word.
- out_ready  input  1  consumer accepts the word.
- fill_mask  output  4  slots written since the last completion/clear (bit k = slot k).
- word_cnt  output  8  completed words, wraps 255 -> 0.
- dup_err  output  1  sticky flag: a slot was written twice within one fill.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = FILL; staging, out_word, fill_mask, word_cnt = 0; out_valid = 0; dup_err = 0.
  - in_ready is forced 0 while rst_n is low.
- States:
  - FILL: in_ready = 1.
  - HOLD: out_valid = 1; in_ready = out_ready (combinational).
- Accept in FILL:
  - staging[slot in_adr] <= in_nib.
  - fill_mask[in_adr] <= 1.
  - If that bit was already 1: the overwrite still happens, dup_err <= 1, and the fill is not counted as complete.
- Completion:
  - Triggered when (fill_mask | onehot(in_adr)) == 4'b1111 on an accept.
  - Next edge: out_word <= merged staging including the accepted nibble; out_valid <= 1; state -> HOLD; fill_mask <= 0; word_cnt <= word_cnt + 1 (mod 256).
  - Latency: out_valid rises exactly 1 cycle after the completing nibble is accepted.
- HOLD:
  - out_word is stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0 and state -> FILL.
  - If in_valid is also high in that cycle, the nibble is accepted into the cleared staging (fill_mask <= onehot(in_adr)).
- Staging word is retained between fills; unwritten slots are never observed because completion requires all four.
- clr (synchronous, highest priority below reset):
  - state -> FILL; fill_mask, staging, dup_err = 0; out_valid = 0.
  - out_word and word_cnt keep their values.
  - An accept in the same cycle as clr is dropped.
- Reset mid-HOLD discards the pending word. Reset mid-FILL discards partial nibbles.
- out_ready while out_valid = 0 is ignored.

Decomposition:
- Shared package holds NIB_W, NUM_NIB, the derived WORD_W, and the FILL/HOLD state encoding; the read-side mux uses the same slot-to-bit map.
- One natural sub-module, nibble_slot_decoder: 2-bit address -> 4-bit one-hot write enable. Everything else stays inline.

Test Plan:
1. Reset: hold rst_n low -> out_valid=0, out_word=0x0000, fill_mask=0000, word_cnt=0, in_ready=0. Release -> in_ready=1.
2. In-order fill: adr0=4, adr1=3, adr2=2, adr3=1 on consecutive cycles, out_ready=1 -> out_word=0x1234, out_valid high for 1 cycle starting 1 cycle after the adr3 accept; word_cnt=1.
3. Out-of-order fill: adr3=A, adr1=B, adr0=C, adr2=D -> out_word=0xADBC; fill_mask steps 1000, 1010, 1011, then 0000.
4. Duplicate write: adr0=5, adr0=6, adr1=7, adr2=8, adr3=9 -> dup_err=1 after the second write; completion only after adr3; out_word=0x9876.
5. Backpressure: complete a word with out_ready=0 for 5 cycles -> in_ready=0 and out_word stable. Then out_ready=1 with in_valid, adr1=E in the same cycle -> out_valid=0 and fill_mask=0010 next cycle.
6. clr after 2 nibbles, then async rst_n pulse mid-HOLD -> clr: fill_mask=0000 and dup_err=0, word_cnt unchanged. rst_n pulse: out_valid drops immediately without a clock edge, word_cnt=0.
